z8_control_unit: RTL and testbench
==================================

// Module: z8_control_unit
//
// PURPOSE
// Multi-cycle sequencer for the z8 core's 4x16 register file: accepts one 16-bit
// instruction per valid/ready handshake, drives the regfile read/write ports,
// computes the ALU result and retires the instruction in 4 cycles.
// Sits between the instruction source and the register file; owns all regfile
// port control.
//
// PARAMETERS
// DATA_WIDTH   16  regfile word width; result, imm zero-extend and flags use it
// ADDR_WIDTH   2   regfile address width (4 registers)
// COUNT_WIDTH  16  width of retired_count
//
// PORTS
// clk              in   1           single clock, all state on posedge
// reset            in   1           synchronous, active-high
// instr_valid      in   1           instr holds a valid instruction
// instr_ready      out  1           1 only in IDLE; transfer when valid&&ready
// instr            in   16          [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm8
// rf_read_addr_a   out  ADDR_WIDTH  = IR.rd, driven from IR in all states
// rf_read_addr_b   out  ADDR_WIDTH  = IR.rs, driven from IR in all states
// rf_read_data_a   in   DATA_WIDTH  combinational regfile read of addr_a
// rf_read_data_b   in   DATA_WIDTH  combinational regfile read of addr_b
// rf_write_addr    out  ADDR_WIDTH  = IR.rd
// rf_write_data    out  DATA_WIDTH  result register
// rf_write_enable  out  1           1 only in WRITEBACK
// flag_zero        out  1           last ALU op result == 0
// flag_carry       out  1           ADD carry-out / SUB borrow
// illegal_op       out  1           1-cycle pulse on undefined opcode
// retire           out  1           1-cycle pulse when an instruction completes
// halted           out  1           1 while in HALTED
// resume           in   1           leave HALTED
// retired_count    out  COUNT_WIDTH retired instructions, wraps at 2^COUNT_WIDTH
//
// BEHAVIOUR
// - Reset (any state, takes priority): state=IDLE, IR=0, result=0, flags=0,
//   count=0. All outputs 0 except instr_ready=1. No regfile write on the reset
//   edge, even if reset arrives mid-instruction.
// - States: IDLE, DECODE, EXECUTE, WRITEBACK, HALTED.
// - IDLE: on valid&&ready, IR<=instr and go to DECODE; otherwise stay in IDLE.
//   instr is ignored in every other state.
// - Opcodes:
//   0 NOP; 1 LDI rd<={0,imm8}; 2 MOV rd<=rs; 3 ADD; 4 SUB (rd<=rd-rs);
//   5 AND; 6 OR; 7 XOR; 8 SHL rd<=rd<<imm8[3:0]; 9 HALT; A-F illegal.
// - DECODE (accept T, this is T+1):
//   - NOP: retire=1, next IDLE.
//   - HALT: retire=1, next HALTED.
//   - Illegal: illegal_op=1, no retire, no count change, next IDLE.
//   - Otherwise: next EXECUTE.
// - EXECUTE (T+2): result<=f(rf_read_data_a, rf_read_data_b, imm).
//   - Flags update only for ops 3-8; MOV/LDI leave flags unchanged.
//   - zero = (result==0).
//   - carry = bit 16 of ADD; carry = borrow (rd<rs unsigned) for SUB; carry=0 for 5-8.
//   - All arithmetic is modulo 2^DATA_WIDTH.
// - WRITEBACK (T+3): rf_write_enable=1, addr=IR.rd, data=result, retire=1;
//   next IDLE, so instr_ready is high at T+4.
// - retire pulse increments retired_count in the same edge; wraps FFFF->0000.
// - HALTED: instr_ready=0, halted=1. resume=1 -> IDLE next cycle.
// - Back-to-back throughput: one ALU op per 4 cycles.
//
// TESTING
// 1 reset held 2 cycles -> instr_ready=1, all other outputs 0, count=0.
// 2 LDI r1,0x34 (0x1434) accepted at T -> at T+3 we=1 addr=1 data=0x0034,
//   retire=1; ready=1 at T+4.
// 3 r1=0xFFFF, r2=0x0001, ADD r1,r2 (0x3600) -> write r1=0x0000, zero=1, carry=1.
// 4 r0=3, r3=5, SUB r0,r3 (0x4300) -> write 0xFFFE, zero=0, carry=1.
// 5 illegal 0xF000 -> illegal_op pulse at T+1, no we, count unchanged, ready at T+2.
// 6 HALT 0x9000 -> halted at T+2, ready=0 until resume, then ready;
//   reset asserted during EXECUTE -> no write, state IDLE.

Source files
------------

// File: rtl/z8_control_unit_if.sv
// z8_control_unit_if: instruction handshake and register-file port bundle for the z8 sequencer.
interface z8_control_unit_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 2,
    parameter int COUNT_WIDTH = 16
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [15:0]            instr;
    logic [ADDR_WIDTH-1:0]  rf_read_addr_a;
    logic [ADDR_WIDTH-1:0]  rf_read_addr_b;
    logic [DATA_WIDTH-1:0]  rf_read_data_a;
    logic [DATA_WIDTH-1:0]  rf_read_data_b;
    logic [ADDR_WIDTH-1:0]  rf_write_addr;
    logic [DATA_WIDTH-1:0]  rf_write_data;
    logic                   rf_write_enable;
    logic                   flag_zero;
    logic                   flag_carry;
    logic                   illegal_op;
    logic                   retire;
    logic                   halted;
    logic                   resume;
    logic [COUNT_WIDTH-1:0] retired_count;

    modport master (
        output instr_valid, instr, rf_read_data_a, rf_read_data_b, resume,
        input  instr_ready, rf_read_addr_a, rf_read_addr_b, rf_write_addr, rf_write_data,
               rf_write_enable, flag_zero, flag_carry, illegal_op, retire, halted, retired_count
    );

    modport slave (
        input  instr_valid, instr, rf_read_data_a, rf_read_data_b, resume,
        output instr_ready, rf_read_addr_a, rf_read_addr_b, rf_write_addr, rf_write_data,
               rf_write_enable, flag_zero, flag_carry, illegal_op, retire, halted, retired_count
    );
endinterface

// File: rtl/z8_control_unit.sv
// z8_control_unit: 4-cycle sequencer owning the 4x16 regfile ports; fetch, decode, execute, writeback.
module z8_control_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    z8_control_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, WRITEBACK, HALTED} state_t;

    state_t                 state, state_next;
    logic [15:0]            ir;
    logic [3:0]             op;
    logic [DATA_WIDTH-1:0]  a, b, imm, alu, result;
    logic [DATA_WIDTH:0]    sum, diff;
    logic                   alu_carry, zero, carry, ready, we, ret, ill;
    logic [COUNT_WIDTH-1:0] count;

    assign op   = ir[15:12];
    assign a    = bus.rf_read_data_a;
    assign b    = bus.rf_read_data_b;
    assign imm  = DATA_WIDTH'(ir[7:0]);
    assign sum  = {1'b0, a} + {1'b0, b};
    // the extra top bit of the difference is the unsigned borrow
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu       = '0;
        alu_carry = 1'b0;
        case (op)
            4'h1:    alu = imm;
            4'h2:    alu = b;
            4'h3:    {alu_carry, alu} = sum;
            4'h4:    {alu_carry, alu} = diff;
            4'h5:    alu = a & b;
            4'h6:    alu = a | b;
            4'h7:    alu = a ^ b;
            4'h8:    alu = a << ir[3:0];
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        we         = 1'b0;
        ret        = 1'b0;
        ill        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) state_next = DECODE;
            end
            DECODE: begin
                ret        = op == 4'h0 || op == 4'h9;
                ill        = op > 4'h9;
                state_next = op == 4'h9 ? HALTED : (op == 4'h0 || ill) ? IDLE : EXECUTE;
            end
            EXECUTE: state_next = WRITEBACK;
            WRITEBACK: begin
                // a reset landing on the writeback edge must not corrupt the regfile
                we         = !reset;
                ret        = 1'b1;
                state_next = IDLE;
            end
            HALTED: if (bus.resume) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ir     <= '0;
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (ready && bus.instr_valid) ir <= bus.instr;
            if (state == EXECUTE) begin
                result <= alu;
                if (op >= 4'h3 && op <= 4'h8) begin
                    zero  <= alu == '0;
                    carry <= alu_carry;
                end
            end
            if (ret) count <= count + COUNT_WIDTH'(1);
        end
    end

    assign bus.instr_ready     = ready;
    assign bus.rf_read_addr_a  = ADDR_WIDTH'(ir[11:10]);
    assign bus.rf_read_addr_b  = ADDR_WIDTH'(ir[9:8]);
    assign bus.rf_write_addr   = ADDR_WIDTH'(ir[11:10]);
    assign bus.rf_write_data   = result;
    assign bus.rf_write_enable = we;
    assign bus.flag_zero       = zero;
    assign bus.flag_carry      = carry;
    assign bus.illegal_op      = ill;
    assign bus.retire          = ret;
    assign bus.halted          = state == HALTED;
    assign bus.retired_count   = count;
endmodule

// File: tb/tb_z8_control_unit.sv
// tb_z8_control_unit: regfile environment, cycle-level behavioural model with per-cycle compare, plus directed literal checks.
module tb_z8_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    z8_control_unit_if bus ();
    z8_control_unit dut (.clk(clk), .reset(reset), .bus(bus));

    logic [15:0] rf [4] = '{default: '0};
    always @(posedge clk) if (bus.rf_write_enable) rf[bus.rf_write_addr] <= bus.rf_write_data;
    assign bus.rf_read_data_a = rf[bus.rf_read_addr_a];
    assign bus.rf_read_data_b = rf[bus.rf_read_addr_b];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted instruction schedules the cycles in which its effects must appear.
    int k = 0, m_free = 0, m_halt_from = 0, m_wb = -1, m_ret = -1, m_ill = -1, m_fl = -1, m_cnt = -1;
    int m_wa = 0, m_wd = 0, mcount = 0;
    int mrf [4] = '{default: 0};
    bit m_halt = 0, started = 0, fz = 0, fc = 0, pz = 0, pc = 0;

    always @(negedge clk) begin : model
        int op, rd, rs, imm, a, b, r, c;
        if (k == m_fl) begin fz = pz; fc = pc; end
        if (k == m_cnt) mcount = (mcount + 1) % 65536;
        if (started) begin
            chk("ready", bus.instr_ready, !m_halt && k >= m_free);
            chk("halted", bus.halted, m_halt && k >= m_halt_from);
            chk("we", bus.rf_write_enable, k == m_wb && !reset);
            chk("retire", bus.retire, k == m_ret);
            chk("illegal", bus.illegal_op, k == m_ill);
            chk("zero", bus.flag_zero, fz);
            chk("carry", bus.flag_carry, fc);
            chk("count", bus.retired_count, mcount);
            if (k == m_wb) begin
                chk("waddr", bus.rf_write_addr, m_wa);
                chk("wdata", bus.rf_write_data, m_wd);
            end
        end
        if (k == m_wb && !reset) mrf[m_wa] = m_wd;
        if (reset) begin
            m_free = k + 1; m_halt = 0; m_wb = -1; m_ret = -1; m_ill = -1; m_fl = -1; m_cnt = -1;
            fz = 0; fc = 0; mcount = 0; started = 1;
        end else if (m_halt && k >= m_halt_from) begin
            if (bus.resume) begin m_halt = 0; m_free = k + 1; end
        end else if (started && !m_halt && bus.instr_valid && k >= m_free) begin
            op = int'(bus.instr[15:12]); rd = int'(bus.instr[11:10]);
            rs = int'(bus.instr[9:8]); imm = int'(bus.instr[7:0]);
            a = mrf[rd]; b = mrf[rs]; r = 0; c = 0;
            if (op == 0) begin
                m_ret = k + 1; m_cnt = k + 2; m_free = k + 2;
            end else if (op == 9) begin
                m_ret = k + 1; m_cnt = k + 2; m_halt = 1; m_halt_from = k + 2;
            end else if (op > 9) begin
                m_ill = k + 1; m_free = k + 2;
            end else begin
                case (op)
                    1: r = imm;
                    2: r = b;
                    3: begin r = (a + b) % 65536; c = int'(a + b > 65535); end
                    4: begin r = (a - b + 65536) % 65536; c = int'(a < b); end
                    5: r = a & b;
                    6: r = a | b;
                    7: r = a ^ b;
                    default: r = (a << (imm % 16)) % 65536;
                endcase
                m_wa = rd; m_wd = r; m_wb = k + 3; m_ret = k + 3; m_cnt = k + 4; m_free = k + 4;
                if (op >= 3) begin pz = r == 0; pc = c != 0; m_fl = k + 3; end
            end
        end
        k++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the cycle after the accepting edge (T+1).
    task automatic issue(input logic [15:0] w);
        int n = 0;
        while (!bus.instr_ready && n < 20) begin step(1); n++; end
        chk("issue_timeout", n < 20, 1);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        step(1);
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.resume = 1'b0;
        step(2);
        reset = 1'b0;
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_we", bus.rf_write_enable, 0);
        chk("rst_flags", {bus.flag_zero, bus.flag_carry, bus.illegal_op, bus.retire, bus.halted}, 0);
        chk("rst_count", bus.retired_count, 0);
        chk("rst_wdata", bus.rf_write_data, 0);

        issue(16'h1434);
        step(2);
        chk("ldi_we", bus.rf_write_enable, 1);
        chk("ldi_addr", bus.rf_write_addr, 1);
        chk("ldi_data", bus.rf_write_data, 16'h0034);
        chk("ldi_retire", bus.retire, 1);
        step(1);
        chk("ldi_ready", bus.instr_ready, 1);

        issue(16'h14FF); issue(16'h8408); issue(16'h18FF); issue(16'h6600); issue(16'h1801);
        issue(16'h3600);
        step(2);
        chk("add_data", bus.rf_write_data, 16'h0000);
        step(1);
        chk("add_zero", bus.flag_zero, 1);
        chk("add_carry", bus.flag_carry, 1);

        issue(16'h1003); issue(16'h1C05); issue(16'h4300);
        step(2);
        chk("sub_data", bus.rf_write_data, 16'hFFFE);
        step(1);
        chk("sub_zero", bus.flag_zero, 0);
        chk("sub_carry", bus.flag_carry, 1);

        issue(16'h5300);
        step(2);
        chk("and_data", bus.rf_write_data, 16'h0004);
        issue(16'h7F00);
        issue(16'h2800);
        step(3);
        chk("mov_keeps_zero", bus.flag_zero, 1);
        issue(16'h0000);
        chk("nop_retire", bus.retire, 1);

        issue(16'hF000);
        chk("ill_pulse", bus.illegal_op, 1);
        chk("ill_noret", bus.retire, 0);
        step(1);
        chk("ill_ready", bus.instr_ready, 1);
        chk("ill_count", bus.retired_count, 14);

        issue(16'h9000);
        chk("halt_retire", bus.retire, 1);
        step(1);
        chk("halt_halted", bus.halted, 1);
        chk("halt_ready", bus.instr_ready, 0);
        bus.instr = 16'h1401;
        bus.instr_valid = 1'b1;
        step(3);
        chk("halt_hold", bus.instr_ready, 0);
        bus.instr_valid = 1'b0;
        bus.resume = 1'b1;
        step(1);
        bus.resume = 1'b0;
        chk("resume_ready", bus.instr_ready, 1);
        chk("resume_count", bus.retired_count, 15);

        issue(16'h1455);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_mid_we", bus.rf_write_enable, 0);
        chk("rst_mid_ready", bus.instr_ready, 1);
        chk("rst_mid_count", bus.retired_count, 0);
        issue(16'h2900);
        step(2);
        chk("rst_mid_r1", bus.rf_write_data, 16'h0000);
        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
